// File: rtl/rotation_pkg.sv
// Shared definitions for the rotation command parser and the dial stage:
// ASCII codes, direction encoding, parser states and byte classifiers.
package rotation_pkg;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    DIGITS,
    SKIP,
    EMIT,
    DONE
  } parser_state_t;

  // Line feed, carriage return and space all end a command line.
  function automatic logic is_terminator(input logic [7:0] b);
    return (b == CH_LF) || (b == CH_CR) || (b == CH_SP);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= (CH_0 + 8'd9));
  endfunction

endpackage

// File: rtl/rotation_cmd_parser_if.sv
// Byte-stream input and decoded-command output of the rotation parser.
// The master side feeds bytes and accepts commands; the slave side is the parser.
interface rotation_cmd_parser_if #(
  parameter int DIST_W = 16
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              cmd_valid;
  logic              cmd_direction;
  logic [DIST_W-1:0] cmd_distance;
  logic              cmd_ready;

  modport master (
    output in_valid, in_data, in_last, cmd_ready,
    input  in_ready, cmd_valid, cmd_direction, cmd_distance
  );

  modport slave (
    input  in_valid, in_data, in_last, cmd_ready,
    output in_ready, cmd_valid, cmd_direction, cmd_distance
  );

endinterface

// File: rtl/rotation_cmd_parser_decimal_accumulator.sv
// Combinational decimal step: acc*10 + digit, clamped to all-ones when the
// result no longer fits in DIST_W bits.
module decimal_accumulator #(
  parameter int DIST_W = 16
) (
  input  logic [DIST_W-1:0] acc,
  input  logic [3:0]        digit,
  output logic [DIST_W-1:0] acc_next,
  output logic              overflow
);

  logic [DIST_W+3:0] wide;

  // Four extra bits hold the worst case (all-ones * 10 + 9) without wrapping.
  always_comb begin
    wide     = ({4'b0000, acc} * (DIST_W+4)'(10)) + (DIST_W+4)'(digit);
    overflow = |wide[DIST_W+3:DIST_W];
    acc_next = overflow ? '1 : wide[DIST_W-1:0];
  end

endmodule

// File: rtl/rotation_cmd_parser.sv
// Parses ASCII rotation commands ("L68\n", "R14\n") into direction/distance
// pairs handed off one at a time on a valid/ready handshake.
module rotation_cmd_parser #(
  parameter int DIST_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rotation_cmd_parser_if.slave bus,
  output logic [CNT_W-1:0]     cmd_count,
  output logic                 parse_error,
  output logic                 overflow,
  output logic                 done
);

  import rotation_pkg::*;

  parser_state_t     state;
  logic [DIST_W-1:0] acc;
  logic [DIST_W-1:0] acc_next;
  logic              acc_ovf;
  logic              digit_seen;
  logic              end_of_stream;
  logic              accept;
  logic [7:0]        din;

  assign accept = bus.in_valid && bus.in_ready;
  assign din    = bus.in_data;

  decimal_accumulator #(.DIST_W(DIST_W)) u_decimal_accumulator (
    .acc      (acc),
    .digit    (din[3:0]),
    .acc_next (acc_next),
    .overflow (acc_ovf)
  );

  // Parser FSM; in_ready and cmd_valid are registered alongside the state so
  // they always agree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      bus.in_ready      <= 1'b1;
      bus.cmd_valid     <= 1'b0;
      bus.cmd_direction <= DIR_L;
      bus.cmd_distance  <= '0;
      acc               <= '0;
      digit_seen        <= 1'b0;
      end_of_stream     <= 1'b0;
      cmd_count         <= '0;
      parse_error       <= 1'b0;
      overflow          <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if ((din == CH_L) || (din == CH_R)) begin
              bus.cmd_direction <= (din == CH_R) ? DIR_R : DIR_L;
              acc               <= '0;
              digit_seen        <= 1'b0;
            end else if (!is_terminator(din)) begin
              parse_error <= 1'b1;
            end
            if (bus.in_last) begin
              state        <= DONE;
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
            end else if ((din == CH_L) || (din == CH_R)) begin
              state <= DIGITS;
            end else if (!is_terminator(din)) begin
              state <= SKIP;
            end
          end
        end
        DIGITS: begin
          if (accept) begin
            if (is_digit(din)) begin
              acc        <= acc_next;
              digit_seen <= 1'b1;
              if (acc_ovf) overflow <= 1'b1;
              if (bus.in_last) begin
                bus.cmd_distance <= acc_next;
                end_of_stream    <= 1'b1;
                state            <= EMIT;
                bus.in_ready     <= 1'b0;
                bus.cmd_valid    <= 1'b1;
              end
            end else if (is_terminator(din) && digit_seen) begin
              bus.cmd_distance <= acc;
              end_of_stream    <= bus.in_last;
              state            <= EMIT;
              bus.in_ready     <= 1'b0;
              bus.cmd_valid    <= 1'b1;
            end else begin
              parse_error <= 1'b1;
              if (bus.in_last) begin
                state        <= DONE;
                bus.in_ready <= 1'b0;
                done         <= 1'b1;
              end else begin
                state <= is_terminator(din) ? IDLE : SKIP;
              end
            end
          end
        end
        SKIP: begin
          if (accept) begin
            if (bus.in_last) begin
              state        <= DONE;
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
            end else if (din == CH_LF) begin
              state <= IDLE;
            end
          end
        end
        EMIT: begin
          if (bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            cmd_count     <= cmd_count + CNT_W'(1);
            if (end_of_stream) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= IDLE;
              bus.in_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          bus.in_ready <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotation_cmd_parser.sv
// Self-checking bench for rotation_cmd_parser: directed streams from the test
// plan plus randomized streams compared against a byte-rule reference model.
module tb_rotation_cmd_parser;

  import rotation_pkg::*;

  localparam int DIST_W = 16;
  localparam int CNT_W  = 16;
  localparam longint DIST_MAX = (64'd1 << DIST_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cmd_count;
  logic             parse_error;
  logic             overflow;
  logic             done;

  rotation_cmd_parser_if #(.DIST_W(DIST_W)) bus ();

  rotation_cmd_parser #(.DIST_W(DIST_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .cmd_count   (cmd_count),
    .parse_error (parse_error),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] stream[$];
  bit         exp_dir[$];
  longint     exp_dist[$];
  bit         exp_perr;
  bit         exp_ovf;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic load_string(input string s);
    for (int k = 0; k < s.len(); k++) stream.push_back(s[k]);
  endtask

  // Reference model: walks the byte list with the line rules, using an
  // unbounded integer accumulator clamped at the distance ceiling.
  task automatic build_expected();
    int     mode = 0;
    longint acc = 0;
    bit     seen = 0;
    bit     dir = 0;
    bit     last;
    logic [7:0] b;
    exp_dir.delete();
    exp_dist.delete();
    exp_perr = 0;
    exp_ovf  = 0;
    for (int i = 0; i < stream.size(); i++) begin
      b    = stream[i];
      last = (i == stream.size() - 1);
      if (mode == 0) begin
        if (b == "L" || b == "R") begin
          dir = (b == "R"); acc = 0; seen = 0; mode = 1;
        end else if (!(b == 8'h0A || b == 8'h0D || b == 8'h20)) begin
          exp_perr = 1; mode = 2;
        end
      end else if (mode == 1) begin
        if (b >= "0" && b <= "9") begin
          acc = acc * 10 + longint'(b - "0");
          if (acc > DIST_MAX) begin acc = DIST_MAX; exp_ovf = 1; end
          seen = 1;
          if (last) begin exp_dir.push_back(dir); exp_dist.push_back(acc); end
        end else if (b == 8'h0A || b == 8'h0D || b == 8'h20) begin
          if (seen) begin exp_dir.push_back(dir); exp_dist.push_back(acc); end
          else exp_perr = 1;
          mode = 0;
        end else begin
          exp_perr = 1; mode = 2;
        end
      end else begin
        if (b == 8'h0A) mode = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", bus.in_ready, 1);
    check_output("rst_cmd_valid", bus.cmd_valid, 0);
    check_output("rst_cmd_count", cmd_count, 0);
    check_output("rst_done", done, 0);
    rst = 1'b0;
  endtask

  // Feeds the stream (optional random gaps) and services commands.
  // ready_mode: 0 = always ready, 1 = random stalls, 2 = 5-cycle stall on first command.
  task automatic apply_stimulus(input string name, input int ready_mode, input int gap_pct);
    int                idx = 0;
    int                hs = 0;
    int                stall_left = 5;
    int                budget = 40 * stream.size() + 200;
    bit                holding = 0;
    bit                held_dir = 0;
    logic [DIST_W-1:0] held_dist = '0;
    build_expected();
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (holding) begin
        check_output({name, "_hold_valid"}, bus.cmd_valid, 1);
        check_output({name, "_hold_dist"}, bus.cmd_distance, held_dist);
        check_output({name, "_hold_dir"}, bus.cmd_direction, held_dir);
        check_output({name, "_hold_in_ready"}, bus.in_ready, 0);
      end
      if (done) break;
      if (ready_mode == 0) bus.cmd_ready = 1'b1;
      else if (ready_mode == 1) bus.cmd_ready = ($urandom_range(0, 2) != 0);
      else if (bus.cmd_valid && stall_left > 0) begin bus.cmd_ready = 1'b0; stall_left--; end
      else bus.cmd_ready = 1'b1;
      if (idx < stream.size()) begin
        bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
        bus.in_data  = stream[idx];
        bus.in_last  = (idx == stream.size() - 1);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (hs < exp_dir.size()) begin
          check_output({name, "_dir"}, bus.cmd_direction, exp_dir[hs]);
          check_output({name, "_dist"}, bus.cmd_distance, exp_dist[hs]);
        end else begin
          check_output({name, "_extra_cmd"}, 1, 0);
        end
        hs++;
      end
      holding   = bus.cmd_valid && !bus.cmd_ready;
      held_dir  = bus.cmd_direction;
      held_dist = bus.cmd_distance;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_output({name, "_handshakes"}, hs, exp_dir.size());
    check_output({name, "_cmd_count"}, cmd_count, exp_dir.size());
    check_output({name, "_parse_error"}, parse_error, exp_perr);
    check_output({name, "_overflow"}, overflow, exp_ovf);
    check_output({name, "_done"}, done, 1);
    check_output({name, "_in_ready_done"}, bus.in_ready, 0);
  endtask

  function automatic string rand_terminator();
    int t = $urandom_range(0, 2);
    return (t == 0) ? "\n" : (t == 1) ? "\r" : " ";
  endfunction

  function automatic string rand_number();
    int k = $urandom_range(0, 3);
    if (k == 0) return $sformatf("%0d", $urandom_range(0, 9));
    if (k == 1) return $sformatf("%0d", $urandom_range(0, 999));
    if (k == 2) return $sformatf("%0d", $urandom_range(60000, 70000));
    return $sformatf("%0d", $urandom_range(100000, 9999999));
  endfunction

  task automatic build_random_stream();
    string junk = "XZ#a";
    string dirs = "LR";
    string s;
    stream.delete();
    for (int i = 0; i < $urandom_range(2, 6); i++) begin
      case ($urandom_range(0, 9))
        0: s = {junk.substr($urandom_range(0, 3), 0), rand_number(), "\n"};
        1: s = {dirs.substr($urandom_range(0, 1), 0), rand_terminator()};
        2: s = {dirs.substr($urandom_range(0, 1), 0), rand_number(), junk.substr($urandom_range(0, 3), 0), rand_number(), "\n"};
        3: s = {"  ", dirs.substr($urandom_range(0, 1), 0), rand_number(), rand_terminator()};
        default: s = {dirs.substr($urandom_range(0, 1), 0), rand_number(), rand_terminator()};
      endcase
      load_string(s);
    end
    s = {dirs.substr($urandom_range(0, 1), 0), rand_number()};
    if ($urandom_range(0, 1) == 1) s = {s, "\n"};
    load_string(s);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.cmd_ready = 1'b0;

    do_reset();
    stream.delete(); load_string("L68\nR14\n");
    apply_stimulus("two_cmds", 0, 0);

    do_reset();
    stream.delete(); load_string("R1000\n");
    apply_stimulus("stall", 2, 0);

    do_reset();
    stream.delete(); load_string("L99999\n");
    apply_stimulus("overflow", 0, 0);

    do_reset();
    stream.delete(); load_string("X12\nR5\n");
    apply_stimulus("junk_line", 0, 0);

    do_reset();
    stream.delete(); load_string("R7");
    apply_stimulus("last_digit", 0, 0);

    do_reset();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = "L";
    @(negedge clk);
    bus.in_data = "1";
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_output("midrst_in_ready", bus.in_ready, 1);
    check_output("midrst_cmd_valid", bus.cmd_valid, 0);
    check_output("midrst_dir", bus.cmd_direction, 0);
    check_output("midrst_dist", bus.cmd_distance, 0);
    check_output("midrst_count", cmd_count, 0);
    check_output("midrst_flags", {parse_error, overflow, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    stream.delete(); load_string("R3\n");
    apply_stimulus("after_rst", 0, 0);

    for (int r = 0; r < 25; r++) begin
      do_reset();
      build_random_stream();
      apply_stimulus($sformatf("rand%0d", r), 1, 30);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
